// File: rtl/mult_share_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: default sizes and FSM states.
// Arbitration policy is chosen by MULT_SHARE_ARB_RR_EN (see mult_share_arb.sv).
package mult_share_arb_pkg;

  localparam int dp_width = 5;
  localparam int n_req    = 4;
  localparam int st_width = 3;

  // Controller phases: grant, pulse start, see the multiplier go busy,
  // wait for it to come back ready, then strobe done.
  typedef enum logic [st_width-1:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BUSY  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/mult_arb_pick.sv
// Combinational winner selection for the shared multiplier.
// With MULT_SHARE_ARB_RR_EN defined the search starts just after ptr (round-robin);
// otherwise the lowest-indexed requester wins and there is no ptr input.
module mult_arb_pick
  import mult_share_arb_pkg::*;
#(
  parameter int N_REQ = n_req
) (
  input  logic [N_REQ-1:0] req,
`ifdef MULT_SHARE_ARB_RR_EN
  input  logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] ptr,
`endif
  output logic [N_REQ-1:0] win
);

`ifdef MULT_SHARE_ARB_RR_EN
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W:0]     sh;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   low1;

  // Rotate so index ptr+1 lands on bit 0, keep the lowest set bit, rotate back.
  // ptr = N_REQ-1 gives a shift of N_REQ, which is the identity rotation.
  always_comb begin
    sh   = {1'b0, ptr} + {{PTR_W{1'b0}}, 1'b1};
    rot  = N_REQ'({req, req} >> sh);
    low1 = rot & (~rot + {{(N_REQ-1){1'b0}}, 1'b1});
    win  = N_REQ'(({low1, low1} << sh) >> N_REQ);
  end
`else
  // Fixed priority: isolate the lowest set request bit.
  always_comb begin
    win = req & (~req + {{(N_REQ-1){1'b0}}, 1'b1});
  end
`endif

endmodule

// File: rtl/mult_share_arb.sv
// Shares one sequential start/rdy multiplier between N_REQ requesters.
// A winner's operands are latched at grant, the multiplier gets a one-cycle start,
// and the registered product is returned with a one-cycle done strobe.
// Build option: MULT_SHARE_ARB_RR_EN selects round-robin arbitration (default: fixed
// priority, lowest index wins, no pointer register).
// Handshake: req is a level held until done; gnt is one-hot from grant through done;
// m_start is a single-cycle pulse; the multiplier is taken as accepted once m_rdy drops,
// and its product is taken on the first m_rdy high after that.
module mult_share_arb
  import mult_share_arb_pkg::*;
#(
  parameter int N_REQ    = n_req,
  parameter int DP_WIDTH = dp_width
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DP_WIDTH-1:0] a_in,
  input  logic [N_REQ*DP_WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [2*DP_WIDTH-1:0]     result,
  output logic                      m_start,
  output logic [DP_WIDTH-1:0]       m_multiplicand,
  output logic [DP_WIDTH-1:0]       m_multiplier,
  input  logic                      m_rdy,
  input  logic [2*DP_WIDTH-1:0]     m_product
);

  arb_state_e          state;
  logic [N_REQ-1:0]    win;
  logic [DP_WIDTH-1:0] a_sel;
  logic [DP_WIDTH-1:0] b_sel;
  logic                take;

`ifdef MULT_SHARE_ARB_RR_EN
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
`endif

  mult_arb_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req (req),
`ifdef MULT_SHARE_ARB_RR_EN
    .ptr (ptr),
`endif
    .win (win)
  );

  // A new operation is accepted only from idle with the multiplier ready.
  assign take = (state == S_IDLE) && (|req) && m_rdy;

  // Route the winner's operands to the latch inputs.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        a_sel = a_in[i*DP_WIDTH +: DP_WIDTH];
        b_sel = b_in[i*DP_WIDTH +: DP_WIDTH];
      end
    end
  end

  // Controller FSM with grant, operand latch, start pulse, result and done strobe.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state          <= S_IDLE;
      gnt            <= '0;
      done           <= '0;
      m_start        <= 1'b0;
      m_multiplicand <= '0;
      m_multiplier   <= '0;
      result         <= '0;
    end else begin
      m_start <= 1'b0;
      done    <= '0;
      case (state)
        S_IDLE: begin
          if (take) begin
            gnt            <= win;
            m_multiplicand <= a_sel;
            m_multiplier   <= b_sel;
            m_start        <= 1'b1;
            state          <= S_START;
          end
        end
        S_START: state <= S_BUSY;
        S_BUSY: begin
          if (!m_rdy) state <= S_WAIT;
        end
        S_WAIT: begin
          if (m_rdy) begin
            result <= m_product;
            done   <= gnt;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          gnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MULT_SHARE_ARB_RR_EN
  // Encode the one-hot winner so it can become the next search origin.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
    end
  end

  // Round-robin pointer remembers the last granted requester.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      ptr <= PTR_W'(N_REQ - 1);
    end else if (take) begin
      ptr <= win_idx;
    end
  end
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb with a behavioural multiplier model
// and an arbitration reference model (RR when MULT_SHARE_ARB_RR_EN is defined).
module tb_mult_share_arb;
  import mult_share_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]     req  = '0;
  logic [N*W-1:0]   a_in = '0;
  logic [N*W-1:0]   b_in = '0;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic [2*W-1:0]   result;
  logic             m_start;
  logic [W-1:0]     m_multiplicand;
  logic [W-1:0]     m_multiplier;
  logic             m_rdy;
  logic [2*W-1:0]   m_product;

  mult_share_arb #(.N_REQ(N), .DP_WIDTH(W)) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .req            (req),
    .a_in           (a_in),
    .b_in           (b_in),
    .gnt            (gnt),
    .done           (done),
    .result         (result),
    .m_start        (m_start),
    .m_multiplicand (m_multiplicand),
    .m_multiplier   (m_multiplier),
    .m_rdy          (m_rdy),
    .m_product      (m_product)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- multiplier model ----------------
  int             busy_len = 2;
  int             busy_cnt = 0;
  logic [2*W-1:0] prod_lat = '0;

  always @(posedge clk) begin
    if (!rst_b) begin
      m_rdy     <= 1'b1;
      m_product <= '0;
      busy_cnt  <= 0;
    end else if (m_start) begin
      m_rdy    <= 1'b0;
      busy_cnt <= busy_len;
      prod_lat <= {{W{1'b0}}, m_multiplicand} * {{W{1'b0}}, m_multiplier};
    end else if (busy_cnt == 1) begin
      busy_cnt  <= 0;
      m_rdy     <= 1'b1;
      m_product <= prod_lat;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // ---------------- monitors ----------------
  int start_cnt      = 0;
  bit multi_hot_seen = 1'b0;

  always @(posedge clk) if (m_start === 1'b1) start_cnt <= start_cnt + 1;
  always @(negedge clk) if (rst_b && $countones(gnt) > 1) multi_hot_seen = 1'b1;

  // ---------------- reference model ----------------
  int             a_op[N];
  int             b_op[N];
  int             model_ptr = N - 1;
  logic [2*W-1:0] exp_q[$];

  function automatic int model_pick(input logic [N-1:0] r, input int ptr);
    int k;
`ifdef MULT_SHARE_ARB_RR_EN
    for (k = 1; k <= N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
`else
    for (k = 0; k < N; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_ops();
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = W'(a_op[i]);
      b_in[i*W +: W] = W'(b_op[i]);
    end
  endtask

  task automatic wait_done(output logic [N-1:0] d_vec, output logic [N-1:0] g_vec,
                           output logic [2*W-1:0] res, output bit timeout);
    timeout = 1'b1;
    d_vec   = '0;
    g_vec   = '0;
    res     = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done !== '0) begin
        d_vec   = done;
        g_vec   = gnt;
        res     = result;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_in_wait(output bit timeout);
    timeout = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (m_start === 1'b1) begin
        timeout = 1'b0;
        break;
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_b = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    checks++; if (gnt !== '0) begin failures++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
    checks++; if (done !== '0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (m_start !== 1'b0) begin failures++; $display("FAIL reset_m_start: got %b expected 0", m_start); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result: got %0d expected 0", result); end
    checks++; if (m_multiplicand !== '0 || m_multiplier !== '0) begin
      failures++; $display("FAIL reset_operands: got %0d,%0d expected 0,0", m_multiplicand, m_multiplier);
    end
    rst_b     = 1'b1;
    model_ptr = N - 1;
    @(negedge clk);
  endtask

  // Requesters in mask each want rem[i] operations; runs until all are served.
  task automatic test_contention(input logic [N-1:0] mask, input int r0, input int r1,
                                 input int r2, input int r3, input bit rand_busy);
    int rem[N];
    int w, base, guard;
    logic [N-1:0] d_vec, g_vec;
    logic [2*W-1:0] res, expv;
    bit to;
    rem[0] = r0; rem[1] = r1; rem[2] = r2; rem[3] = r3;
    apply_ops();
    req   = mask;
    guard = 0;
    while (req != '0 && guard < 40) begin
      guard++;
      if (rand_busy) busy_len = $urandom_range(1, 6);
      w = model_pick(req, model_ptr);
      exp_q.push_back((2*W)'(a_op[w] * b_op[w]));
      base = start_cnt;
      wait_done(d_vec, g_vec, res, to);
      checks++;
      if (to) begin
        failures++; $display("FAIL done_timeout: got no done expected done[%0d]", w);
        void'(exp_q.pop_front());
        break;
      end
      expv = exp_q.pop_front();
      checks++; if (d_vec !== (N'(1) << w)) begin failures++; $display("FAIL done_vec: got %b expected %b", d_vec, N'(1) << w); end
      checks++; if (g_vec !== (N'(1) << w)) begin failures++; $display("FAIL gnt_at_done: got %b expected %b", g_vec, N'(1) << w); end
      checks++; if (res !== expv) begin failures++; $display("FAIL result: got %0d expected %0d (req %0d)", res, expv, w); end
      checks++; if (start_cnt - base != 1) begin failures++; $display("FAIL start_pulses: got %0d expected 1", start_cnt - base); end
      model_ptr = w;
      rem[w]--;
      if (rem[w] <= 0) req[w] = 1'b0;
    end
    repeat (3) @(negedge clk);
    checks++; if (gnt !== '0) begin failures++; $display("FAIL idle_gnt: got %b expected 0", gnt); end
  endtask

  task automatic test_single();
    a_op = '{23, 0, 0, 0};
    b_op = '{19, 0, 0, 0};
    busy_len = 5;
    test_contention(4'b0001, 1, 0, 0, 0, 1'b0);
    checks++; if (result !== 10'd437) begin failures++; $display("FAIL result_held: got %0d expected 437", result); end
  endtask

  task automatic test_all_req();
    a_op = '{3, 5, 7, 9};
    b_op = '{4, 6, 8, 10};
    test_contention(4'b1111, 3, 1, 1, 1, 1'b1);
  endtask

  task automatic test_pair();
    a_op = '{1, 11, 2, 13};
    b_op = '{1, 12, 2, 14};
    test_contention(4'b1010, 0, 2, 0, 2, 1'b1);
    checks++; if (multi_hot_seen !== 1'b0) begin failures++; $display("FAIL gnt_multi_hot: got 1 expected 0"); end
  endtask

  task automatic test_drop_midop();
    bit to;
    logic [N-1:0] d_vec, g_vec;
    logic [2*W-1:0] res;
    a_op = '{6, 0, 0, 0};
    b_op = '{7, 0, 0, 0};
    apply_ops();
    busy_len = 6;
    req = 4'b0001;
    wait_in_wait(to);
    checks++; if (to) begin failures++; $display("FAIL drop_start_timeout: got no m_start expected pulse"); end
    req = '0;
    a_in[0 +: W] = W'(31);
    b_in[0 +: W] = W'(2);
    @(negedge clk);
    checks++; if (m_multiplicand !== W'(6)) begin failures++; $display("FAIL latched_a: got %0d expected 6", m_multiplicand); end
    wait_done(d_vec, g_vec, res, to);
    checks++; if (to || d_vec !== 4'b0001) begin failures++; $display("FAIL drop_done: got %b expected 0001", d_vec); end
    checks++; if (res !== 10'd42) begin failures++; $display("FAIL drop_result: got %0d expected 42", res); end
    model_ptr = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    bit to;
    a_op = '{2, 9, 0, 0};
    b_op = '{3, 9, 0, 0};
    apply_ops();
    busy_len = 6;
    req = 4'b0010;
    wait_in_wait(to);
    checks++; if (to) begin failures++; $display("FAIL rst_start_timeout: got no m_start expected pulse"); end
    rst_b = 1'b0;
    req   = '0;
    @(negedge clk);
    checks++; if (gnt !== '0) begin failures++; $display("FAIL midrst_gnt: got %b expected 0", gnt); end
    checks++; if (done !== '0) begin failures++; $display("FAIL midrst_done: got %b expected 0", done); end
    checks++; if (m_start !== 1'b0) begin failures++; $display("FAIL midrst_m_start: got %b expected 0", m_start); end
    checks++; if (result !== '0) begin failures++; $display("FAIL midrst_result: got %0d expected 0", result); end
    rst_b     = 1'b1;
    model_ptr = N - 1;
    busy_len  = 2;
    @(negedge clk);
    test_contention(4'b0001, 1, 0, 0, 0, 1'b0);
  endtask

  task automatic test_extremes();
    a_op = '{31, 0, 0, 0};
    b_op = '{31, 0, 0, 0};
    test_contention(4'b0001, 1, 0, 0, 0, 1'b1);
    checks++; if (result !== 10'd961) begin failures++; $display("FAIL max_product: got %0d expected 961", result); end
    a_op = '{0, 0, 0, 0};
    b_op = '{31, 0, 0, 0};
    test_contention(4'b0001, 1, 0, 0, 0, 1'b1);
    checks++; if (result !== 10'd0) begin failures++; $display("FAIL zero_product: got %0d expected 0", result); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        a_op[i] = $urandom_range(0, 31);
        b_op[i] = $urandom_range(0, 31);
      end
      test_contention(N'($urandom_range(1, 15)), $urandom_range(1, 2), $urandom_range(1, 2),
                      $urandom_range(1, 2), $urandom_range(1, 2), 1'b1);
    end
    checks++; if (multi_hot_seen !== 1'b0) begin failures++; $display("FAIL gnt_multi_hot_random: got 1 expected 0"); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_pair();
    test_drop_midop();
    test_reset_midop();
    test_extremes();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
